// File: rtl/rom_clip_player_pkg.sv
// Shared types and constants for the multi-clip ROM player.
package rom_clip_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_WRITE,
    ST_WAIT
  } state_e;

  localparam int DEF_OUT_W    = 32;
  localparam int DEF_SAMPLE_W = 16;
  localparam int VOL_MAX      = DEF_OUT_W - DEF_SAMPLE_W;
  localparam int DIV_22K      = 2272;

  // Limit a requested left shift so a full-scale sample cannot be shifted out entirely.
  function automatic logic [4:0] clamp_vol(input logic [4:0] v, input int lim);
    return (int'(v) > lim) ? 5'(lim) : v;
  endfunction

endpackage

// File: rtl/rom_clip_player_tick.sv
// Loadable sample-period divider: tick fires once every (div+1) enabled clocks.
module sample_tick_gen #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             clr,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;

  // Tick on terminal count; suppressed in the cycle a new period is loaded.
  assign tick = en & ~load & ~clr & (count_q == div_q);

  // Next count: load and clear restart the period, otherwise wrap at div.
  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    if (load) begin
      div_d   = div_in;
      count_d = '0;
    end else if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == div_q) ? '0 : count_q + 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      div_q   <= '0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/rom_clip_player.sv
// Plays one of NUM_CLIPS ROM clips into the Audio_Controller write port.
module rom_clip_player
  import rom_clip_player_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int DIV_W     = 12,
  parameter int NUM_CLIPS = 4,
  parameter int SEL_W     = 2,
  parameter int ROM_LAT   = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [NUM_CLIPS*ADDR_W-1:0] clip_start_tbl,
  input  logic [NUM_CLIPS*ADDR_W-1:0] clip_end_tbl,
  input  logic [SEL_W-1:0]            clip_sel,
  input  logic                        play,
  input  logic                        stop,
  input  logic                        loop,
  input  logic [DIV_W-1:0]            rate_div,
  input  logic [4:0]                  vol_shift,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [SAMPLE_W-1:0]         rom_q,
  input  logic                        audio_out_allowed,
  output logic                        write_audio_out,
  output logic [OUT_W-1:0]            left_channel_audio_out,
  output logic [OUT_W-1:0]            right_channel_audio_out,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);

  localparam int         VOL_LIM  = OUT_W - SAMPLE_W;
  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic                loop_q, loop_d;
  logic [4:0]          vol_q, vol_d;
  logic [1:0]          lat_q, lat_d;
  logic [OUT_W-1:0]    sample_q, sample_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic                tick, load;
  logic [ADDR_W-1:0]   sel_start, sel_end;
  logic [OUT_W-1:0]    sext;
  logic                play_go, stop_go;

  assign sel_start = clip_start_tbl[int'(clip_sel)*ADDR_W +: ADDR_W];
  assign sel_end   = clip_end_tbl[int'(clip_sel)*ADDR_W +: ADDR_W];
  assign sext      = {{(OUT_W-SAMPLE_W){rom_q[SAMPLE_W-1]}}, rom_q};

  // Stop dominates a simultaneous play.
  assign play_go = play & ~stop;
  assign stop_go = stop & busy;

  assign busy                    = (state_q != ST_IDLE);
  assign rom_addr                = cur_q;
  assign write_audio_out         = (state_q == ST_WRITE) & audio_out_allowed;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign done                    = done_q;
  assign overrun                 = ovr_q;

  sample_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (CLOCK_50),
    .rst    (reset),
    .load   (load),
    .div_in (rate_div),
    .clr    (~busy),
    .en     (busy),
    .tick   (tick)
  );

  // Player FSM: command handling first, then per-state sequencing.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    start_d  = start_q;
    end_d    = end_q;
    loop_d   = loop_q;
    vol_d    = vol_q;
    lat_d    = lat_q;
    sample_d = sample_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    load     = 1'b0;
    if (stop_go) begin
      state_d  = ST_IDLE;
      cur_d    = '0;
      sample_d = '0;
      done_d   = 1'b1;
    end else if (play_go) begin
      if (sel_start > sel_end) begin
        // Empty/inverted clip: refuse and signal completion immediately.
        state_d  = ST_IDLE;
        cur_d    = '0;
        sample_d = '0;
        done_d   = 1'b1;
      end else begin
        load    = 1'b1;
        state_d = ST_FETCH;
        cur_d   = sel_start;
        start_d = sel_start;
        end_d   = sel_end;
        loop_d  = loop;
        vol_d   = clamp_vol(vol_shift, VOL_LIM);
        lat_d   = '0;
        ovr_d   = 1'b0;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (tick) ovr_d = 1'b1;
          if (lat_q == LAT_LAST) state_d = ST_CAPTURE;
          else lat_d = lat_q + 1'b1;
        end
        ST_CAPTURE: begin
          if (tick) ovr_d = 1'b1;
          sample_d = sext << vol_q;
          state_d  = ST_WRITE;
        end
        ST_WRITE: begin
          if (tick) ovr_d = 1'b1;
          if (audio_out_allowed) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (tick) begin
            if (cur_q != end_q) begin
              cur_d   = cur_q + 1'b1;
              lat_d   = '0;
              state_d = ST_FETCH;
            end else if (loop_q) begin
              cur_d   = start_q;
              lat_d   = '0;
              state_d = ST_FETCH;
            end else begin
              state_d  = ST_IDLE;
              cur_d    = '0;
              sample_d = '0;
              done_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Player state registers; reset aborts any clip in progress.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      start_q  <= '0;
      end_q    <= '0;
      loop_q   <= 1'b0;
      vol_q    <= '0;
      lat_q    <= '0;
      sample_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      start_q  <= start_d;
      end_q    <= end_d;
      loop_q   <= loop_d;
      vol_q    <= vol_d;
      lat_q    <= lat_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule
